// File: rtl/chacha_prng_stream_pkg.sv
// Shared types, constants and ChaCha round helpers for the keystream generator.
package chacha_prng_stream_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BLOCK_WORDS = 16;
    localparam int unsigned KEY_W       = 384;
    localparam int unsigned CTR_W       = 64;
    localparam int unsigned SEED_W      = KEY_W + CTR_W;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [BLOCK_WORDS-1:0][WORD_W-1:0] block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        STALL = 2'd3
    } state_t;

    localparam word_t SIGMA0 = 32'h6170_7865;
    localparam word_t SIGMA1 = 32'h3320_646e;
    localparam word_t SIGMA2 = 32'h7962_2d32;
    localparam word_t SIGMA3 = 32'h6b20_6574;

    function automatic word_t rotl(word_t x, int unsigned n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

    function automatic block_t quarter_round(block_t s, logic [3:0] a, logic [3:0] b,
                                             logic [3:0] c, logic [3:0] d);
        block_t t;
        t    = s;
        t[a] = t[a] + t[b];
        t[d] = rotl(t[d] ^ t[a], 16);
        t[c] = t[c] + t[d];
        t[b] = rotl(t[b] ^ t[c], 12);
        t[a] = t[a] + t[b];
        t[d] = rotl(t[d] ^ t[a], 8);
        t[c] = t[c] + t[d];
        t[b] = rotl(t[b] ^ t[c], 7);
        return t;
    endfunction

    function automatic block_t column_round(block_t s);
        block_t t;
        t = quarter_round(s, 4'd0, 4'd4, 4'd8,  4'd12);
        t = quarter_round(t, 4'd1, 4'd5, 4'd9,  4'd13);
        t = quarter_round(t, 4'd2, 4'd6, 4'd10, 4'd14);
        t = quarter_round(t, 4'd3, 4'd7, 4'd11, 4'd15);
        return t;
    endfunction

    function automatic block_t diagonal_round(block_t s);
        block_t t;
        t = quarter_round(s, 4'd0, 4'd5, 4'd10, 4'd15);
        t = quarter_round(t, 4'd1, 4'd6, 4'd11, 4'd12);
        t = quarter_round(t, 4'd2, 4'd7, 4'd8,  4'd13);
        t = quarter_round(t, 4'd3, 4'd4, 4'd9,  4'd14);
        return t;
    endfunction

    // Initial state for one block: constants, seed words, counter folded into words 14/15.
    function automatic block_t init_block(logic [KEY_W-1:0] key, logic [CTR_W-1:0] ctr);
        block_t b;
        b     = block_t'({key, SIGMA3, SIGMA2, SIGMA1, SIGMA0});
        b[14] = b[14] ^ ctr[31:0];
        b[15] = b[15] ^ ctr[63:32];
        return b;
    endfunction

    function automatic block_t feed_forward(block_t perm, block_t ff_in);
        block_t r;
        for (int unsigned j = 0; j < BLOCK_WORDS; j++) begin
            r[4'(j)] = perm[4'(j)] + ff_in[4'(j)];
        end
        return r;
    endfunction

endpackage

// File: rtl/chacha_dround_pipe.sv
// One ChaCha double round as two registered stages (column, then diagonal), fed back on itself.
module chacha_dround_pipe
    import chacha_prng_stream_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   start,
    input  block_t init,
    output block_t dround_q
);

    block_t col_q;
    block_t col_src;

    assign col_src = start ? init : dround_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q    <= '0;
            dround_q <= '0;
        end else begin
            col_q    <= column_round(col_src);
            dround_q <= diagonal_round(col_q);
        end
    end

endmodule

// File: rtl/chacha_prng_stream.sv
// ChaCha keystream generator: LANES parallel cores feeding a ping-pong output buffer.
module chacha_prng_stream
    import chacha_prng_stream_pkg::*;
#(
    parameter int unsigned LANES         = 2,
    parameter int unsigned DOUBLE_ROUNDS = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          seed_valid,
    output logic                          seed_ready,
    input  logic [SEED_W-1:0]             seed_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BLOCK_WORDS*WORD_W-1:0] out_data,
    output logic                          busy
);

    localparam int unsigned STEPS  = 2 * DOUBLE_ROUNDS;
    localparam int unsigned CNT_W  = $clog2(STEPS + 1);
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_t             state, state_nxt;
    logic [KEY_W-1:0]   key_q;
    logic [CTR_W-1:0]   ctr_q, ctr_nxt;
    logic [CNT_W-1:0]   step_q, step_nxt;
    logic [1:0]         full_q, full_nxt;
    logic               wr_bank_q, wr_bank_nxt;
    logic               rd_bank_q, rd_bank_nxt;
    logic [LANE_W-1:0]  rd_lane_q, rd_lane_nxt;
    logic               ov_nxt;
    block_t             od_nxt;
    block_t             bank_q [2][LANES];

    block_t             init_blk [LANES];
    block_t             perm_blk [LANES];
    block_t             sum_blk  [LANES];

    logic               seed_hs, pop, pop_last, core_start, grp_done, other_free;

    // Per-lane core: lane i runs counter base+i.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign init_blk[l] = init_block(key_q, ctr_q + CTR_W'(l));
        assign sum_blk[l]  = feed_forward(perm_blk[l], init_blk[l]);

        chacha_dround_pipe u_pipe (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (core_start),
            .init     (init_blk[l]),
            .dround_q (perm_blk[l])
        );
    end

    always_comb begin
        seed_hs    = seed_valid & seed_ready;
        pop        = out_valid & out_ready;
        pop_last   = pop & (rd_lane_q == LANE_W'(LANES - 1));
        core_start = (state == RUN) && (step_q == '0);
        grp_done   = (state == RUN) && (step_q == CNT_W'(STEPS));
        // The bank after the one being written must be empty (or emptied now) to keep computing.
        other_free = !full_q[~wr_bank_q] || (pop_last && (rd_bank_q != wr_bank_q));
    end

    always_comb begin
        state_nxt   = state;
        ctr_nxt     = ctr_q;
        step_nxt    = step_q;
        full_nxt    = full_q;
        wr_bank_nxt = wr_bank_q;
        rd_bank_nxt = rd_bank_q;
        rd_lane_nxt = rd_lane_q;
        ov_nxt      = 1'b0;
        od_nxt      = '0;

        if (pop) begin
            if (pop_last) begin
                full_nxt[rd_bank_q] = 1'b0;
                rd_bank_nxt         = ~rd_bank_q;
                rd_lane_nxt         = '0;
            end else begin
                rd_lane_nxt = rd_lane_q + LANE_W'(1);
            end
        end

        case (state)
            IDLE: ;
            LOAD: begin
                state_nxt = RUN;
                step_nxt  = '0;
            end
            RUN: begin
                if (grp_done) begin
                    full_nxt[wr_bank_q] = 1'b1;
                    wr_bank_nxt         = ~wr_bank_q;
                    ctr_nxt             = ctr_q + CTR_W'(LANES);
                    step_nxt            = '0;
                    state_nxt           = other_free ? RUN : STALL;
                end else begin
                    step_nxt = step_q + CNT_W'(1);
                end
            end
            STALL: begin
                if (pop_last) begin
                    state_nxt = RUN;
                    step_nxt  = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Reseed wins over everything after the output beat has been taken.
        if (seed_hs) begin
            state_nxt   = LOAD;
            ctr_nxt     = seed_data[KEY_W +: CTR_W];
            step_nxt    = '0;
            full_nxt    = '0;
            wr_bank_nxt = 1'b0;
            rd_bank_nxt = 1'b0;
            rd_lane_nxt = '0;
        end

        ov_nxt = full_nxt[rd_bank_nxt];
        if (ov_nxt) begin
            if (grp_done && (wr_bank_q == rd_bank_nxt)) begin
                od_nxt = sum_blk[rd_lane_nxt];
            end else begin
                od_nxt = bank_q[rd_bank_nxt][rd_lane_nxt];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            key_q      <= '0;
            ctr_q      <= '0;
            step_q     <= '0;
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_lane_q  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            busy       <= 1'b0;
            seed_ready <= 1'b0;
        end else begin
            state      <= state_nxt;
            ctr_q      <= ctr_nxt;
            step_q     <= step_nxt;
            full_q     <= full_nxt;
            wr_bank_q  <= wr_bank_nxt;
            rd_bank_q  <= rd_bank_nxt;
            rd_lane_q  <= rd_lane_nxt;
            out_valid  <= ov_nxt;
            out_data   <= od_nxt;
            seed_ready <= 1'b1;
            if (seed_hs) begin
                busy  <= 1'b1;
                key_q <= seed_data[KEY_W-1:0];
            end
        end
    end

    // Bank payload needs no reset; validity lives in full_q.
    always_ff @(posedge clk) begin
        if (grp_done) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                bank_q[wr_bank_q][LANE_W'(l)] <= sum_blk[LANE_W'(l)];
            end
        end
    end

endmodule
